// File: rtl/sfp_norm_row.sv
// Row normalizer: captures a psum row, forms its abs-sum, divides each lane by (local + peer) sum.
// Latency col+1 cycles from div accept to the valid pulse; no backpressure, acc/div are ignored while busy.
module sfp_norm_row #(
    parameter int bw_psum = 20,
    parameter int col     = 8,
    parameter int frac    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw_psum*col-1:0] in,
    input  logic                   acc,
    input  logic                   div,
    input  logic [bw_psum+3:0]     sum_in,
    output logic [bw_psum+3:0]     sum_out,
    output logic [bw_psum*col-1:0] out,
    output logic                   busy,
    output logic                   valid
);

    localparam int sw = bw_psum + 4;
    localparam int cw = (col > 1) ? $clog2(col) : 1;
    localparam int dw = bw_psum + frac + 5;

    typedef enum logic [1:0] {IDLE, SUMRDY, DIV, DONE} state_t;

    state_t state_q, state_nxt;

    logic [bw_psum*col-1:0] row_q;
    logic [bw_psum*col-1:0] out_q;
    logic [sw-1:0]          sum_q;
    logic [sw-1:0]          total_q;
    logic [cw-1:0]          cnt_q;
    logic                   valid_q;

    logic load_row, load_total, lane_we, set_valid, last_lane;

    logic [bw_psum:0]         lane_ext;
    logic [bw_psum:0]         lane_abs;
    logic [sw-1:0]            abs_sum;
    logic signed [bw_psum-1:0] lane_val;
    logic signed [dw-1:0]     num_ext;
    logic signed [dw-1:0]     den_ext;
    logic [bw_psum-1:0]       lane_res;

    // Abs-sum of the incoming row; bw_psum+4 bits cannot overflow for the lane counts used.
    always_comb begin
        abs_sum  = '0;
        lane_ext = '0;
        lane_abs = '0;
        for (int k = 0; k < col; k++) begin
            lane_ext = {in[bw_psum*k+bw_psum-1], in[bw_psum*k +: bw_psum]};
            lane_abs = lane_ext[bw_psum] ? -lane_ext : lane_ext;
            abs_sum  = abs_sum + sw'(lane_abs);
        end
    end

    // One lane per cycle: signed (lane <<< frac) over the unsigned total, truncated toward zero.
    always_comb begin
        lane_val = row_q[cnt_q*bw_psum +: bw_psum];
        num_ext  = {{(dw-bw_psum){lane_val[bw_psum-1]}}, lane_val} <<< frac;
        den_ext  = {{(dw-sw){1'b0}}, total_q};
        lane_res = '0;
        if (total_q != '0) begin
            lane_res = bw_psum'(num_ext / den_ext);
        end
    end

    assign last_lane = (cnt_q == cw'(col - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        load_row   = 1'b0;
        load_total = 1'b0;
        lane_we    = 1'b0;
        set_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    load_row  = 1'b1;
                    state_nxt = SUMRDY;
                end
            end
            SUMRDY: begin
                if (div) begin
                    load_total = 1'b1;
                    state_nxt  = DIV;
                end else if (acc) begin
                    load_row = 1'b1;
                end
            end
            DIV: begin
                lane_we = 1'b1;
                if (last_lane) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                set_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q   <= '0;
            sum_q   <= '0;
            total_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= set_valid;
            if (load_row) begin
                row_q <= in;
                sum_q <= abs_sum;
            end
            // sum_in is only looked at here, on the div-accept edge.
            if (load_total) begin
                total_q <= sum_q + sum_in;
                cnt_q   <= '0;
            end
            if (lane_we) begin
                out_q[cnt_q*bw_psum +: bw_psum] <= lane_res;
                cnt_q <= last_lane ? '0 : cnt_q + cw'(1);
            end
        end
    end

    assign sum_out = sum_q;
    assign out     = out_q;
    assign busy    = (state_q == DIV);
    assign valid   = valid_q;

endmodule

// File: tb/tb_sfp_norm_row.sv
// Table-driven bench for sfp_norm_row with an expected-row scoreboard queue.
module tb_sfp_norm_row;

    localparam int BW   = 20;
    localparam int COL  = 8;
    localparam int FRAC = 8;
    localparam int NV   = 8;

    logic            clk;
    logic            reset;
    logic [BW*COL-1:0] in_row;
    logic            acc;
    logic            div;
    logic [BW+3:0]   sum_in;
    logic [BW+3:0]   sum_out;
    logic [BW*COL-1:0] out;
    logic            busy;
    logic            valid;

    sfp_norm_row #(.bw_psum(BW), .col(COL), .frac(FRAC)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_row),
        .acc    (acc),
        .div    (div),
        .sum_in (sum_in),
        .sum_out(sum_out),
        .out    (out),
        .busy   (busy),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [159:0] row;
        logic [23:0]  sum_in;
        logic [23:0]  exp_sum;
        logic [159:0] exp_out;
    } vec_t;

    vec_t         tbl[NV];
    logic [159:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    function automatic logic [159:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        int a[8];
        logic [159:0] p;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        a[4] = a4; a[5] = a5; a[6] = a6; a[7] = a7;
        p = '0;
        for (int k = 0; k < 8; k++) p[k*20 +: 20] = 20'(a[k]);
        return p;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input bit acc_in_div, input logic [159:0] alt_row);
        int lat;
        int bcnt;
        bit got;
        logic [159:0] e;
        in_row = v.row;
        acc = 1'b1;
        step();
        acc = 1'b0;
        chk({v.name, " sum_out"}, 160'(sum_out), 160'(v.exp_sum));
        sum_in = v.sum_in;
        div = 1'b1;
        exp_q.push_back(v.exp_out);
        step();
        div = 1'b0;
        sum_in = 24'hABCDEF;
        if (acc_in_div) begin
            in_row = alt_row;
            acc = 1'b1;
        end
        lat = 0;
        bcnt = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (busy) bcnt++;
            if (valid) got = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        acc = 1'b0;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({v.name, " latency"}, 160'(lat), 160'(COL + 1));
        chk({v.name, " out"}, out, e);
        chk({v.name, " busy cycles"}, 160'(bcnt), 160'(COL));
        step();
        chk({v.name, " valid one cycle"}, 160'(valid), 160'(0));
        if (acc_in_div) chk({v.name, " sum_out after acc in DIV"}, 160'(sum_out), 160'(v.exp_sum));
    endtask

    initial begin : main
        logic         vflag;
        logic [159:0] prev;
        vec_t         v1;

        tbl[0] = '{"single", pack8(512, -256, 256, 0, 0, 0, 0, 0), 24'd0, 24'd1024,
                   pack8(128, -64, 64, 0, 0, 0, 0, 0)};
        tbl[1] = '{"two_core", pack8(512, -256, 256, 0, 0, 0, 0, 0), 24'd1024, 24'd1024,
                   pack8(64, -32, 32, 0, 0, 0, 0, 0)};
        tbl[2] = '{"trunc", pack8(-1, 2, 0, 0, 0, 0, 0, 0), 24'd0, 24'd3,
                   pack8(-85, 170, 0, 0, 0, 0, 0, 0)};
        tbl[3] = '{"zero_div", pack8(0, 0, 0, 0, 0, 0, 0, 0), 24'd0, 24'd0,
                   pack8(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4] = '{"min_neg", pack8(-524288, 0, 0, 0, 0, 0, 0, 0), 24'd0, 24'd524288,
                   pack8(-256, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{"total_wrap", pack8(256, 0, 0, 0, 0, 0, 0, 0), 24'hFFFF80, 24'd256,
                   pack8(512, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6] = '{"big_peer", pack8(100, -100, 0, 0, 0, 0, 0, 0), 24'd16777000, 24'd200,
                   pack8(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7] = '{"mixed", pack8(1000, -3000, 7, -7, 0, 0, 0, 100), 24'd0, 24'd4114,
                   pack8(62, -186, 0, 0, 0, 0, 0, 6)};
        v1 = tbl[0];

        // Reset held with both controls asserted.
        in_row = v1.row;
        sum_in = 24'd7;
        reset = 1'b1;
        acc = 1'b1;
        div = 1'b1;
        vflag = 1'b0;
        repeat (3) begin
            step();
            if (valid) vflag = 1'b1;
        end
        chk("reset out", out, '0);
        chk("reset sum_out", 160'(sum_out), 160'(0));
        chk("reset busy", 160'(busy), 160'(0));
        chk("reset valid", 160'(vflag), 160'(0));
        reset = 1'b0;
        acc = 1'b0;
        div = 1'b0;

        // div alone in IDLE does nothing.
        sum_in = 24'd5;
        div = 1'b1;
        step();
        div = 1'b0;
        chk("idle div busy", 160'(busy), 160'(0));
        step();
        chk("idle div out", out, '0);
        chk("idle div valid", 160'(valid), 160'(0));

        // acc+div in IDLE acts as acc only; a following acc in SUMRDY recaptures.
        in_row = tbl[2].row;
        sum_in = 24'd0;
        acc = 1'b1;
        div = 1'b1;
        step();
        acc = 1'b0;
        div = 1'b0;
        chk("accdiv busy", 160'(busy), 160'(0));
        chk("accdiv sum_out", 160'(sum_out), 160'(3));
        run_vec(v1, 1'b0, '0);

        // acc during DIV must not disturb the row or the local sum.
        run_vec(tbl[1], 1'b1, tbl[2].row);

        for (int i = 0; i < NV; i++) run_vec(tbl[i], 1'b0, '0);

        // Reset arriving on the edge that would process lane 4.
        prev = tbl[NV-1].exp_out;
        in_row = v1.row;
        acc = 1'b1;
        step();
        acc = 1'b0;
        sum_in = 24'd0;
        div = 1'b1;
        step();
        div = 1'b0;
        repeat (4) step();
        chk("partial out", out, {prev[159:80], v1.exp_out[79:0]});
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset out", out, '0);
        chk("midreset sum_out", 160'(sum_out), 160'(0));
        chk("midreset busy", 160'(busy), 160'(0));
        vflag = valid;
        repeat (12) begin
            step();
            if (valid) vflag = 1'b1;
        end
        chk("midreset no valid", 160'(vflag), 160'(0));

        run_vec(tbl[3], 1'b0, '0);
        chk("scoreboard empty", 160'(exp_q.size()), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
